// File: rtl/csc_dec_dbg_pkg.sv
// Shared definitions for the csc_dec debug stages: FSM encoding, detection
// counter width and report record layout.
package csc_dec_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dl_state_e;

  localparam int DL_COUNT_W = 8;

  // Report record: {mon_id, timestamp}, timestamp in the low bits.
  localparam int RPT_TS_LSB = 0;

  function automatic int rpt_id_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int rpt_w(input int id_w, input int ts_w);
    return id_w + ts_w;
  endfunction

endpackage

// File: rtl/csc_dec_dbg_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set bit,
// 0 when no bit is set.
module csc_dec_dbg_prio_enc #(
  parameter int NUM_MON = 4,
  parameter int ID_W    = 4
) (
  input  logic [NUM_MON-1:0] blk,
  output logic [ID_W-1:0]    id
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    id = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (blk[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/csc_dec_hls_deadlock_report_unit.sv
// Deadlock report unit: qualifies monitor block flags over a persistence
// window, latches the first offender plus a timestamp, pulses irq and hands
// a record to the debug logger over valid/ready.
module csc_dec_hls_deadlock_report_unit
  import csc_dec_dbg_pkg::*;
#(
  parameter int NUM_MON  = 4,
  parameter int THRESH_W = 16,
  parameter int TS_W     = 32,
  parameter int ID_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_MON-1:0]    mon_block,
  input  logic [THRESH_W-1:0]   cfg_thresh,
  input  logic                  clr,
  output logic                  irq,
  output logic                  dl_detect,
  output logic [ID_W-1:0]       dl_mon_id,
  output logic [TS_W-1:0]       dl_timestamp,
  output logic [DL_COUNT_W-1:0] dl_count,
  output logic                  report_valid,
  input  logic                  report_ready,
  output logic [ID_W+TS_W-1:0]  report_data
);

  dl_state_e           state;
  logic [TS_W-1:0]     ts;
  logic [THRESH_W-1:0] cnt;
  logic [THRESH_W-1:0] thr;
  logic [ID_W-1:0]     low_id;
  logic                any_blk;
  logic                hit;

  assign any_blk = |mon_block;
  assign thr     = (cfg_thresh == '0) ? THRESH_W'(1) : cfg_thresh;
  // >= rather than == so that lowering cfg_thresh below the running count
  // fires at once instead of letting cnt run on towards overflow.
  assign hit     = any_blk && (cnt >= thr - THRESH_W'(1));

  csc_dec_dbg_prio_enc #(
    .NUM_MON (NUM_MON),
    .ID_W    (ID_W)
  ) u_prio (
    .blk (mon_block),
    .id  (low_id)
  );

  // Free-running cycle timestamp.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + TS_W'(1);
  end

  // Detection FSM with persistence counter, capture registers and handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      irq          <= 1'b0;
      dl_detect    <= 1'b0;
      dl_mon_id    <= '0;
      dl_timestamp <= '0;
      dl_count     <= '0;
      report_valid <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable) state <= ARMED;
        end
        ARMED: begin
          if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (hit) begin
            state        <= REPORT;
            cnt          <= '0;
            irq          <= 1'b1;
            dl_detect    <= 1'b1;
            dl_mon_id    <= low_id;
            dl_timestamp <= ts;
            report_valid <= 1'b1;
            if (dl_count != '1) dl_count <= dl_count + DL_COUNT_W'(1);
          end else if (any_blk) begin
            cnt <= cnt + THRESH_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        REPORT: begin
          // enable, clr and mon_block are deliberately ignored here.
          if (report_ready) begin
            report_valid <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (clr) begin
            dl_detect    <= 1'b0;
            dl_mon_id    <= '0;
            dl_timestamp <= '0;
            cnt          <= '0;
            state        <= enable ? ARMED : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign report_data = {dl_mon_id, dl_timestamp};

endmodule
